// File: rtl/local_mem_pkg.sv
// Shared constants and types for the pipelined local memory model.
// Defaults here seed the top-level parameters; the response struct matches the default widths.
package local_mem_pkg;

    localparam int LM_DATA_WIDTH = 512;
    localparam int LM_ADDR_WIDTH = 26;
    localparam int LM_TAG_WIDTH  = 56;
    localparam int LM_MEM_WORDS  = 4096;
    localparam int LM_LATENCY    = 4;
    localparam int LM_RSP_DEPTH  = 8;

    typedef struct packed {
        logic [LM_DATA_WIDTH-1:0] data;
        logic [LM_TAG_WIDTH-1:0]  tag;
    } mem_rsp_t;

    // Width of an index into n entries, never below one bit.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/local_mem_rsp_fifo.sv
// In-order response FIFO; a push into a full FIFO is legal only alongside a pop,
// which frees the slot being written.
module local_mem_rsp_fifo
    import local_mem_pkg::*;
#(
    parameter int DEPTH = LM_RSP_DEPTH,
    parameter int WIDTH = LM_DATA_WIDTH + LM_TAG_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty
);

    localparam int PW = index_width(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = storage[rd_ptr_q[PW-1:0]];

    // NOTE: every always_comb output gets a default before any condition so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage carries no reset; only the pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr_q[PW-1:0]] <= push_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && full && !pop));

endmodule

// File: rtl/local_mem_pipelined.sv
// Byte-writable local memory with a fixed-latency read pipeline, credit-based flow
// control and an in-order response FIFO. Out-of-range accesses raise a sticky flag.
module local_mem_pipelined
    import local_mem_pkg::*;
#(
    parameter int DATA_WIDTH = LM_DATA_WIDTH,
    parameter int ADDR_WIDTH = LM_ADDR_WIDTH,
    parameter int TAG_WIDTH  = LM_TAG_WIDTH,
    parameter int MEM_WORDS  = LM_MEM_WORDS,
    parameter int LATENCY    = LM_LATENCY,
    parameter int RSP_DEPTH  = LM_RSP_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_req_valid,
    input  logic                    mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_req_ready,
    output logic                    mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                    mem_rsp_ready,
    output logic                    busy,
    output logic                    tb_addr_out_of_bounds
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = index_width(MEM_WORDS);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS);
    localparam logic [CNT_W-1:0]    CREDIT_MAX = CNT_W'(RSP_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);

    logic [DATA_WIDTH-1:0] mem_array [MEM_WORDS];

    logic                  in_range;
    logic [IDX_W-1:0]      req_idx;
    logic                  accept;
    logic                  accept_rd;
    logic                  accept_wr;
    logic                  rsp_pop;

    logic [LATENCY-1:0]    pipe_valid_q, pipe_valid_d;
    rsp_t [LATENCY-1:0]    pipe_rsp_q,   pipe_rsp_d;

    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic                  oob_q, oob_d;

    rsp_t                  fifo_head;
    logic                  fifo_empty;

    // Request side.
    assign in_range  = ({1'b0, mem_req_addr} < ADDR_LIMIT);
    assign req_idx   = mem_req_addr[IDX_W-1:0];
    assign accept    = mem_req_valid && mem_req_ready;
    assign accept_rd = accept && !mem_req_rw;
    assign accept_wr = accept && mem_req_rw;

    // Ready depends only on the registered credit count, never on this cycle's inputs.
    assign mem_req_ready = (outstanding_q < CREDIT_MAX);
    assign busy          = (outstanding_q != '0);

    // Response side.
    assign mem_rsp_valid         = !fifo_empty;
    assign mem_rsp_data          = fifo_head.data;
    assign mem_rsp_tag           = fifo_head.tag;
    assign rsp_pop               = mem_rsp_valid && mem_rsp_ready;
    assign tb_addr_out_of_bounds = oob_q;

    // Byte-masked write at the accept edge; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (accept_wr && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (mem_req_byteen[b]) mem_array[req_idx][8*b +: 8] <= mem_req_data[8*b +: 8];
            end
        end
    end

    // Stage 0 captures the array at the accept edge, so it sees every earlier write.
    always_comb begin
        pipe_valid_d = '0;
        pipe_rsp_d   = '0;
        pipe_valid_d[0]      = accept_rd;
        pipe_rsp_d[0].data   = in_range ? mem_array[req_idx] : '0;
        pipe_rsp_d[0].tag    = mem_req_tag;
        for (int s = 1; s < LATENCY; s++) begin
            pipe_valid_d[s] = pipe_valid_q[s-1];
            pipe_rsp_d[s]   = pipe_rsp_q[s-1];
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept_rd && !rsp_pop)      outstanding_d = outstanding_q + CNT_W'(1);
        else if (!accept_rd && rsp_pop) outstanding_d = outstanding_q - CNT_W'(1);
    end

    always_comb begin
        oob_d = oob_q;
        if (accept && !in_range) oob_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid_q  <= '0;
            outstanding_q <= '0;
            oob_q         <= 1'b0;
        end else begin
            pipe_valid_q  <= pipe_valid_d;
            outstanding_q <= outstanding_d;
            oob_q         <= oob_d;
        end
    end

    // Payload registers only load behind a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        for (int s = 0; s < LATENCY; s++) begin
            if (pipe_valid_d[s]) pipe_rsp_q[s] <= pipe_rsp_d[s];
        end
    end

    local_mem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (RSP_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pipe_valid_q[LATENCY-1]),
        .push_data (pipe_rsp_q[LATENCY-1]),
        .pop       (mem_rsp_ready),
        .head_data (fifo_head),
        .empty     (fifo_empty)
    );

    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        outstanding_q <= CREDIT_MAX);

    a_head_stable: assert property (@(posedge clk) disable iff (reset)
        (mem_rsp_valid && !mem_rsp_ready) |=> (mem_rsp_valid && $stable(fifo_head)));

endmodule

// File: tb/tb_local_mem_pipelined.sv
// Self-checking bench: a word-array model plus an expected-response queue predict
// every response, credit state and the out-of-bounds flag.
module tb_local_mem_pipelined;
    import local_mem_pkg::*;

    localparam int DW    = LM_DATA_WIDTH;
    localparam int AW    = LM_ADDR_WIDTH;
    localparam int TW    = LM_TAG_WIDTH;
    localparam int WORDS = LM_MEM_WORDS;
    localparam int LAT   = LM_LATENCY;
    localparam int DEPTH = LM_RSP_DEPTH;
    localparam int BYTES = DW / 8;
    localparam int IW    = $clog2(WORDS);
    localparam int TEST_WORDS = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             mem_req_valid;
    logic             mem_req_rw;
    logic [BYTES-1:0] mem_req_byteen;
    logic [AW-1:0]    mem_req_addr;
    logic [DW-1:0]    mem_req_data;
    logic [TW-1:0]    mem_req_tag;
    logic             mem_req_ready;
    logic             mem_rsp_valid;
    logic [DW-1:0]    mem_rsp_data;
    logic [TW-1:0]    mem_rsp_tag;
    logic             mem_rsp_ready;
    logic             busy;
    logic             tb_addr_out_of_bounds;

    local_mem_pipelined dut (
        .clk                   (clk),
        .reset                 (reset),
        .mem_req_valid         (mem_req_valid),
        .mem_req_rw            (mem_req_rw),
        .mem_req_byteen        (mem_req_byteen),
        .mem_req_addr          (mem_req_addr),
        .mem_req_data          (mem_req_data),
        .mem_req_tag           (mem_req_tag),
        .mem_req_ready         (mem_req_ready),
        .mem_rsp_valid         (mem_rsp_valid),
        .mem_rsp_data          (mem_rsp_data),
        .mem_rsp_tag           (mem_rsp_tag),
        .mem_rsp_ready         (mem_rsp_ready),
        .busy                  (busy),
        .tb_addr_out_of_bounds (tb_addr_out_of_bounds)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model_mem [WORDS];
    mem_rsp_t      exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req();
        mem_req_valid  = 1'b0;
        mem_req_rw     = 1'b0;
        mem_req_byteen = '0;
        mem_req_addr   = '0;
        mem_req_data   = '0;
        mem_req_tag    = '0;
    endtask

    task automatic drive_read(input logic [AW-1:0] a, input logic [TW-1:0] t);
        mem_req_valid  = 1'b1;
        mem_req_rw     = 1'b0;
        mem_req_byteen = '0;
        mem_req_addr   = a;
        mem_req_data   = '0;
        mem_req_tag    = t;
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [BYTES-1:0] be,
                               input logic [DW-1:0] d);
        mem_req_valid  = 1'b1;
        mem_req_rw     = 1'b1;
        mem_req_byteen = be;
        mem_req_addr   = a;
        mem_req_data   = d;
        mem_req_tag    = '0;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, TEST_WORDS - 1));
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a < AW'(WORDS)) return model_mem[a[IW-1:0]];
        return '0;
    endfunction

    // Apply the request currently on the bus to the model if the DUT accepts it this cycle.
    task automatic note_accept();
        mem_rsp_t e;
        if (mem_req_valid && mem_req_ready) begin
            if (mem_req_rw) begin
                if (mem_req_addr < AW'(WORDS)) begin
                    for (int b = 0; b < BYTES; b++)
                        if (mem_req_byteen[b])
                            model_mem[mem_req_addr[IW-1:0]][8*b +: 8] = mem_req_data[8*b +: 8];
                end
            end else begin
                e.data = model_read(mem_req_addr);
                e.tag  = mem_req_tag;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic note_pop();
        if (mem_rsp_valid && mem_rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic test_reset();
        idle_req();
        mem_rsp_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (mem_req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", mem_req_ready);
        end
        checks++;
        if (mem_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid: got %b want 0", mem_rsp_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (tb_addr_out_of_bounds !== 1'b0) begin
            errors++; $display("FAIL reset_oob: got %b want 0", tb_addr_out_of_bounds);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic init_memory();
        for (int a = 0; a < TEST_WORDS; a++) begin
            drive_write(AW'(a), '1, rand_word());
            note_accept();
            tick();
        end
        idle_req();
        tick();
        checks++;
        if (mem_rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_no_rsp: got valid=%b busy=%b want 0/0", mem_rsp_valid, busy);
        end
    endtask

    task automatic test_byte_write();
        logic [DW-1:0] d;
        mem_rsp_t      e;
        d = rand_word();
        d[7:0] = 8'hA5;
        drive_write(AW'('h10), BYTES'(1), d);
        note_accept();
        tick();
        drive_read(AW'('h10), TW'(3));
        note_accept();
        tick();
        idle_req();
        for (int k = 0; k <= LAT; k++) begin
            checks++;
            if (mem_rsp_valid !== (k == LAT)) begin
                errors++;
                $display("FAIL latency: %0d cycles after accept valid=%b want %b", k, mem_rsp_valid, (k == LAT));
            end
            if (k < LAT) tick();
        end
        e = exp_q[0];
        checks++;
        if (mem_rsp_data !== e.data || mem_rsp_tag !== e.tag) begin
            errors++;
            $display("FAIL byte_write_rsp: got tag %h data %h want tag %h data %h", mem_rsp_tag, mem_rsp_data, e.tag, e.data);
        end
        checks++;
        if (mem_rsp_data[7:0] !== 8'hA5 || mem_rsp_tag !== TW'(3)) begin
            errors++;
            $display("FAIL byte0: got byte0 %h tag %h want a5 tag 3", mem_rsp_data[7:0], mem_rsp_tag);
        end
        mem_rsp_ready = 1'b1;
        note_pop();
        tick();
        mem_rsp_ready = 1'b0;
        checks++;
        if (mem_rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_pop: got valid=%b busy=%b want 0/0", mem_rsp_valid, busy);
        end
    endtask

    task automatic test_credit();
        int            n_acc;
        int            got;
        logic [DW-1:0] held_data;
        logic [TW-1:0] held_tag;
        mem_rsp_t      e;
        mem_rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (!mem_req_ready) break;
            drive_read(rand_addr(), TW'(n_acc));
            note_accept();
            tick();
            n_acc++;
        end
        idle_req();
        checks++;
        if (n_acc != DEPTH) begin
            errors++; $display("FAIL credit_count: got %0d accepted want %0d", n_acc, DEPTH);
        end
        checks++;
        if (mem_req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL credit_full: got ready=%b busy=%b want 0/1", mem_req_ready, busy);
        end
        for (int c = 0; c < LAT + 2; c++) tick();
        held_data = mem_rsp_data;
        held_tag  = mem_rsp_tag;
        tick();
        checks++;
        if (mem_rsp_valid !== 1'b1 || mem_rsp_data !== held_data || mem_rsp_tag !== held_tag) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b tag %h want valid=1 tag %h", mem_rsp_valid, mem_rsp_tag, held_tag);
        end
        mem_rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 4 * DEPTH && got < DEPTH; c++) begin
            if (mem_rsp_valid) begin
                e = exp_q[0];
                checks++;
                if (mem_rsp_tag !== TW'(got) || mem_rsp_data !== e.data) begin
                    errors++;
                    $display("FAIL credit_order: got tag %h data %h want tag %h data %h", mem_rsp_tag, mem_rsp_data, TW'(got), e.data);
                end
                note_pop();
                got++;
            end
            tick();
        end
        checks++;
        if (got != DEPTH || busy !== 1'b0 || mem_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL credit_drain: got %0d rsp busy=%b ready=%b want %0d/0/1", got, busy, mem_req_ready, DEPTH);
        end
        mem_rsp_ready = 1'b0;
    endtask

    task automatic wait_and_check_rsp(input string name);
        mem_rsp_t e;
        for (int c = 0; c < LAT + 4 && !mem_rsp_valid; c++) tick();
        checks++;
        if (!mem_rsp_valid || exp_q.size() == 0) begin
            errors++; $display("FAIL %s: no response within bound, valid=%b", name, mem_rsp_valid);
        end else begin
            e = exp_q[0];
            if (mem_rsp_data !== e.data || mem_rsp_tag !== e.tag) begin
                errors++;
                $display("FAIL %s: got tag %h data %h want tag %h data %h", name, mem_rsp_tag, mem_rsp_data, e.tag, e.data);
            end
        end
        note_pop();
        tick();
    endtask

    task automatic test_out_of_bounds();
        mem_rsp_ready = 1'b1;
        drive_read(AW'(WORDS), TW'(7));
        note_accept();
        tick();
        idle_req();
        checks++;
        if (tb_addr_out_of_bounds !== 1'b1) begin
            errors++; $display("FAIL oob_set: got %b want 1", tb_addr_out_of_bounds);
        end
        checks++;
        if (exp_q[0].data !== '0) begin
            errors++; $display("FAIL oob_model: expected zero data for out-of-range read");
        end
        wait_and_check_rsp("oob_read");
        drive_write(AW'(WORDS + 'h10), '1, rand_word());
        note_accept();
        tick();
        drive_read(AW'('h10), TW'(8));
        note_accept();
        tick();
        idle_req();
        wait_and_check_rsp("oob_write_dropped");
        checks++;
        if (tb_addr_out_of_bounds !== 1'b1) begin
            errors++; $display("FAIL oob_sticky: got %b want 1", tb_addr_out_of_bounds);
        end
        mem_rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        localparam int N = 16;
        logic     exp_valid;
        mem_rsp_t e;
        mem_rsp_ready = 1'b1;
        for (int s = 0; s <= N + LAT + 1; s++) begin
            exp_valid = (s >= LAT + 1) && (s <= N + LAT);
            checks++;
            if (mem_rsp_valid !== exp_valid) begin
                errors++; $display("FAIL b2b_valid: step %0d got %b want %b", s, mem_rsp_valid, exp_valid);
            end
            if (mem_rsp_valid && exp_q.size() > 0) begin
                e = exp_q[0];
                checks++;
                if (mem_rsp_data !== e.data || mem_rsp_tag !== e.tag) begin
                    errors++;
                    $display("FAIL b2b_data: step %0d got tag %h want tag %h", s, mem_rsp_tag, e.tag);
                end
            end
            if (s == N + LAT || s == N + LAT + 1) begin
                checks++;
                if (busy !== (s == N + LAT)) begin
                    errors++; $display("FAIL b2b_busy: step %0d got %b want %b", s, busy, (s == N + LAT));
                end
            end
            note_pop();
            if (s < N) begin
                checks++;
                if (mem_req_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready: step %0d got 0 want 1", s);
                end
                drive_read(rand_addr(), TW'('h100 + s));
            end else begin
                idle_req();
            end
            note_accept();
            tick();
        end
        mem_rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        mem_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_read(rand_addr(), TW'('h200 + i));
            note_accept();
            tick();
        end
        idle_req();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        checks++;
        if (busy !== 1'b0 || mem_req_ready !== 1'b1 || tb_addr_out_of_bounds !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got busy=%b ready=%b oob=%b want 0/1/0", busy, mem_req_ready, tb_addr_out_of_bounds);
        end
        mem_rsp_ready = 1'b1;
        for (int c = 0; c < LAT + 4; c++) begin
            checks++;
            if (mem_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_ghost: cycle %0d got valid=1 want 0", c);
            end
            tick();
        end
        drive_read(AW'('h10), TW'('h2A));
        note_accept();
        tick();
        idle_req();
        wait_and_check_rsp("midreset_retained");
        mem_rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        int       accepted;
        int       cycles;
        mem_rsp_t e;
        accepted = 0;
        cycles   = 0;
        while (accepted < 1000 && cycles < 8000) begin
            mem_rsp_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0) begin
                logic [AW-1:0] a;
                a = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(WORDS, (1 << AW) - 1)) : rand_addr();
                if ($urandom_range(0, 1) == 1) drive_write(a, {$urandom, $urandom}, rand_word());
                else drive_read(a, {$urandom, $urandom});
            end else begin
                idle_req();
            end
            checks++;
            if (mem_req_ready !== (exp_q.size() < DEPTH) || busy !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL rand_credit: got ready=%b busy=%b with %0d outstanding", mem_req_ready, busy, exp_q.size());
            end
            if (mem_rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected: got tag %h want no response", mem_rsp_tag);
                end else begin
                    e = exp_q[0];
                    if (mem_rsp_data !== e.data || mem_rsp_tag !== e.tag) begin
                        errors++;
                        $display("FAIL rand_rsp: got tag %h data %h want tag %h data %h", mem_rsp_tag, mem_rsp_data, e.tag, e.data);
                    end
                end
            end
            if (mem_req_valid && mem_req_ready) accepted++;
            note_pop();
            note_accept();
            tick();
            cycles++;
        end
        checks++;
        if (accepted < 1000) begin
            errors++; $display("FAIL rand_progress: got %0d accepted want 1000", accepted);
        end
        idle_req();
        mem_rsp_ready = 1'b1;
        for (int c = 0; c < LAT + 2 * DEPTH + 4; c++) begin
            if (mem_rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL drain_unexpected: got tag %h want no response", mem_rsp_tag);
                end else begin
                    e = exp_q[0];
                    if (mem_rsp_data !== e.data || mem_rsp_tag !== e.tag) begin
                        errors++;
                        $display("FAIL drain_rsp: got tag %h want tag %h", mem_rsp_tag, e.tag);
                    end
                end
            end
            note_pop();
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0 || mem_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: got %0d missing busy=%b valid=%b want 0/0/0", exp_q.size(), busy, mem_rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        init_memory();
        test_byte_write();
        test_credit();
        test_out_of_bounds();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/local_mem_pipelined.md
LOCAL_MEM_PIPELINED -- requirements
Module: local_mem_pipelined

Interface
REQ-001 Parameter DATA_WIDTH, default 512: data bus width in bits, a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 26: word address width.
REQ-003 Parameter TAG_WIDTH, default 56: request/response tag width.
REQ-004 Parameter MEM_WORDS, default 4096: implemented depth in DATA_WIDTH words, at most 2**ADDR_WIDTH.
REQ-005 Parameter LATENCY, default 4: read pipeline stages, at least 1.
REQ-006 Parameter RSP_DEPTH, default 8: maximum outstanding reads; a power of two, at least 2.
REQ-007 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-008 Port reset, input, 1: asynchronous, active-high reset.
REQ-009 Port mem_req_valid, input, 1: request present.
REQ-010 Port mem_req_rw, input, 1: 1 = write, 0 = read.
REQ-011 Port mem_req_byteen, input, DATA_WIDTH/8: write byte enables.
REQ-012 Port mem_req_addr, input, ADDR_WIDTH: word address.
REQ-013 Port mem_req_data, input, DATA_WIDTH: write data.
REQ-014 Port mem_req_tag, input, TAG_WIDTH: request tag.
REQ-015 Port mem_req_ready, output, 1: request accepted this cycle if valid.
REQ-016 Port mem_rsp_valid, output, 1: read response present.
REQ-017 Port mem_rsp_data, output, DATA_WIDTH: read data.
REQ-018 Port mem_rsp_tag, output, TAG_WIDTH: tag of the read being answered.
REQ-019 Port mem_rsp_ready, input, 1: consumer accepts the response.
REQ-020 Port busy, output, 1: at least one read outstanding.
REQ-021 Port tb_addr_out_of_bounds, output, 1: sticky flag, set by any accepted out-of-range request.

Function
REQ-022 Accept = mem_req_valid & mem_req_ready; mem_req_ready SHALL equal (outstanding < RSP_DEPTH), driven from registered state only.
REQ-023 outstanding SHALL increment on an accepted read and decrement on a response pop (mem_rsp_valid & mem_rsp_ready); a simultaneous accept and pop SHALL leave it unchanged.
REQ-024 Writes SHALL not consume credit; an in-range accepted write SHALL update only the bytes whose byteen bit is set, at the accept edge, and SHALL produce no response.
REQ-025 An accepted read SHALL sample array contents at the accept edge, so it sees all writes accepted on earlier edges.
REQ-026 The read data and tag SHALL traverse exactly LATENCY registered stages, then enter an in-order response FIFO of depth RSP_DEPTH.
REQ-027 For a read accepted at edge N with an empty FIFO, mem_rsp_valid SHALL first be high in the cycle after edge N+LATENCY.
REQ-028 mem_rsp_valid SHALL equal FIFO not-empty; mem_rsp_data and mem_rsp_tag SHALL be the FIFO head and SHALL hold stable while valid & !ready.
REQ-029 Responses SHALL return in request order; tags are passed through unmodified.
REQ-030 The credit rule SHALL guarantee the FIFO never overflows; a push into a full FIFO is an assertion failure.
REQ-031 Out-of-range (addr >= MEM_WORDS): a write SHALL be dropped; a read SHALL return all-zero data with its tag; tb_addr_out_of_bounds SHALL set on the accept edge and stay set until reset.
REQ-032 busy SHALL equal (outstanding != 0).
REQ-033 A pipeline stage pushing into the FIFO while the head is popped in the same cycle SHALL be handled without loss, including with the FIFO full.

Reset
REQ-034 Reset SHALL clear the pipeline valid bits, FIFO pointers, outstanding count and tb_addr_out_of_bounds.
REQ-035 During reset, mem_req_ready SHALL be 1, and mem_rsp_valid, busy and tb_addr_out_of_bounds SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight reads; no response for them SHALL ever appear.
REQ-037 Array contents SHALL not be reset.

Structure
REQ-038 Package local_mem_pkg SHALL hold the default width, depth and latency constants and a response struct {data, tag}.
REQ-039 The response FIFO SHALL be a sub-module named local_mem_rsp_fifo, parametrised by RSP_DEPTH and the struct width.

Verification
REQ-040 Write 0xA5 to byte 0 of addr 0x10 with byteen=1, then read 0x10 with tag 0x3 -> response data byte0=0xA5, other bytes at their prior values, tag 0x3, valid first seen at N+LATENCY+1.
REQ-041 mem_rsp_ready held 0; issue reads until mem_req_ready drops -> exactly RSP_DEPTH (8) accepted; then raise ready -> 8 responses in tag order 0..7.
REQ-042 Read addr MEM_WORDS (4096) with tag 0x7 -> zero data, tag 0x7, tb_addr_out_of_bounds=1, and it stays 1 through later in-range traffic.
REQ-043 Back-to-back reads on every cycle with mem_rsp_ready=1 -> one response per cycle after the latency fill, and busy=0 one cycle after the last pop.
REQ-044 Three reads in flight, then reset for 1 cycle -> no responses afterwards, outstanding=0, and data written before reset is still readable.
REQ-045 mem_rsp_ready toggling randomly for 1000 mixed reads and writes against a scoreboard -> no data, tag or order mismatches.
